// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states, data width.
package mem_pkg;
  localparam int DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {IDLE, RMW_WR} state_t;
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load return path: little-endian lane select followed by sign or zero extension.
module load_extend
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              zext,
  output logic [DATA_W-1:0] data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    data     = word;
    // Half lane ignores lane[0] so force-aligned halfword accesses fall out naturally.
    case (size)
      SIZE_BYTE: data = {{(DATA_W-8){byte_sel[7] & ~zext}}, byte_sel};
      SIZE_HALF: data = {{(DATA_W-16){half_sel[15] & ~zext}}, half_sel};
      default:   data = word;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Pipeline-to-data-memory adapter: sub-word loads/stores, 2-cycle RMW for byte/half stores.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN enables misalignment trapping; otherwise force-aligns.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              misalign_exc,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_data;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] ext_data;
  logic              is_word;
  logic              misalign;
  logic              go;
  logic              sub_store;

  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] word,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [1:0]        size,
                                                   input logic [1:0]        lane);
    logic [DATA_W-1:0] m;
    m = word;
    if (size == SIZE_BYTE) m[{lane, 3'b000} +: 8] = wdata[7:0];
    else                   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return m;
  endfunction

  // Reserved size 2'b11 behaves as a word access.
  assign is_word   = req_size[1];
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign = (req_size == SIZE_HALF && req_addr[0]) ||
                    (is_word && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign go        = req_valid && !misalign && state == IDLE;
  assign sub_store = go && req_write && !is_word;

  load_extend u_load_extend (
    .word (mem_rdata),
    .size (req_size),
    .lane (req_addr[1:0]),
    .zext (req_unsigned),
    .data (ext_data)
  );

  always_comb begin
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == RMW_WR) begin
      mem_write = 1'b1;
      mem_addr  = rmw_addr;
      mem_wdata = rmw_data;
    end else if (go) begin
      mem_addr = word_addr;
      if (!req_write) begin
        mem_read = 1'b1;
      end else if (is_word) begin
        mem_write = 1'b1;
        mem_wdata = req_wdata;
      end else begin
        mem_read = 1'b1;
        stall    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      load_data    <= '0;
      load_valid   <= 1'b0;
      misalign_exc <= 1'b0;
      rmw_addr     <= '0;
      rmw_data     <= '0;
    end else begin
      load_valid   <= go && !req_write;
      misalign_exc <= req_valid && misalign && state == IDLE;
      if (go && !req_write) load_data <= ext_data;
      case (state)
        IDLE: begin
          if (sub_store) begin
            rmw_addr <= word_addr;
            rmw_data <= merge_lane(mem_rdata, req_wdata, req_size, req_addr[1:0]);
            state    <= RMW_WR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a load-result scoreboard.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, misalign_exc, mem_read, mem_write;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  int total = 0;
  int bad = 0;
  logic [31:0] sb_q[$];

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misalign_exc(misalign_exc), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = v; req_write = w; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic check_ret(input logic exp_vld, input string tag);
    chk({tag, "_vld"}, {31'd0, load_valid}, {31'd0, exp_vld});
    if (load_valid && sb_q.size() > 0) chk({tag, "_data"}, load_data, sb_q.pop_front());
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp, input string tag);
    drive(1'b1, 1'b0, size, uns, addr, 32'd0);
    #1;
    chk({tag, "_rd"}, {31'd0, mem_read}, 32'd1);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    sb_q.push_back(exp);
    tick();
    check_ret(1'b1, tag);
  endtask

  task automatic idle_cycle(input string tag);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    tick();
    check_ret(1'b0, tag);
  endtask

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    preload(6'd8, 32'h80FF7F01);
    preload(6'd10, 32'h11223344);
    @(negedge clk);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    do_load(32'h23, 2'b00, 1'b0, 32'hFFFFFF80, "lb23");
    idle_cycle("lb23_pulse");
    do_load(32'h23, 2'b00, 1'b1, 32'h00000080, "lbu23");
    idle_cycle("lbu23_pulse");
    do_load(32'h22, 2'b01, 1'b0, 32'hFFFF80FF, "lh22");
    do_load(32'h20, 2'b01, 1'b1, 32'h00007F01, "lhu20");
    do_load(32'h20, 2'b10, 1'b0, 32'h80FF7F01, "lw20");
    idle_cycle("lw20_pulse");

    // Byte store: one stalled read cycle, then the merged write.
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    #1;
    chk("sb_stall1", {31'd0, stall}, 32'd1);
    chk("sb_rd1", {31'd0, mem_read}, 32'd1);
    chk("sb_wr1", {31'd0, mem_write}, 32'd0);
    tick();
    chk("sb_stall2", {31'd0, stall}, 32'd0);
    chk("sb_wr2", {31'd0, mem_write}, 32'd1);
    chk("sb_rd2", {31'd0, mem_read}, 32'd0);
    chk("sb_addr2", mem_addr, 32'h20);
    chk("sb_wdata2", mem_wdata, 32'h80FFAA01);
    check_ret(1'b0, "sb_noload");
    tick();
    do_load(32'h20, 2'b10, 1'b0, 32'h80FFAA01, "lw_after_sb");

    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'hDEADBEEF);
    #1;
    chk("sw_stall", {31'd0, stall}, 32'd0);
    chk("sw_wr", {31'd0, mem_write}, 32'd1);
    chk("sw_rd", {31'd0, mem_read}, 32'd0);
    chk("sw_addr", mem_addr, 32'h24);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    do_load(32'h24, 2'b10, 1'b0, 32'hDEADBEEF, "lw24");

    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h26, 32'h00001234);
    #1;
    chk("sh_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("sh_stall2", {31'd0, stall}, 32'd0);
    chk("sh_wr2", {31'd0, mem_write}, 32'd1);
    chk("sh_wdata2", mem_wdata, 32'h1234BEEF);
    tick();
    do_load(32'h24, 2'b10, 1'b0, 32'h1234BEEF, "lw24_after_sh");

    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'd0);
    #1;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("mis_rd", {31'd0, mem_read}, 32'd0);
    chk("mis_wr", {31'd0, mem_write}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
    check_ret(1'b0, "mis_noload");
    idle_cycle("mis_after");
    chk("mis_exc_pulse", {31'd0, misalign_exc}, 32'd0);
`else
    chk("fa_rd", {31'd0, mem_read}, 32'd1);
    chk("fa_addr", mem_addr, 32'h20);
    sb_q.push_back(32'h80FFAA01);
    tick();
    check_ret(1'b1, "fa_lw22");
    chk("fa_exc", {31'd0, misalign_exc}, 32'd0);
`endif

    // Reset arrives while the halfword store sits in RMW_WR.
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h28, 32'h00005555);
    #1;
    chk("rrmw_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("rrmw_wr_pending", {31'd0, mem_write}, 32'd1);
    #1;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_size = 0; req_addr = 0; req_wdata = 0;
    #1;
    chk("rrmw_wr", {31'd0, mem_write}, 32'd0);
    chk("rrmw_rd", {31'd0, mem_read}, 32'd0);
    chk("rrmw_stall", {31'd0, stall}, 32'd0);
    chk("rrmw_addr", mem_addr, 32'd0);
    chk("rrmw_wdata", mem_wdata, 32'd0);
    chk("rrmw_load_data", load_data, 32'd0);
    chk("rrmw_load_valid", {31'd0, load_valid}, 32'd0);
    tick();
    chk("rrmw_mem28", mem[10], 32'h11223344);
    @(negedge clk);
    rst = 1'b0;
    do_load(32'h28, 2'b10, 1'b0, 32'h11223344, "lw28_after_rst");
    idle_cycle("final_idle");
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and the word-addressed data memory, which has combinational read and word-only synchronous write.
- Converts pipeline load/store requests of byte, halfword and word size into word memory accesses.
- Implements byte/halfword stores as a 2-cycle read-modify-write, stalling the pipeline for one cycle.
- Performs load lane selection and sign/zero extension; delivers a registered load result to MEM/WB.

Parameters:
- ADDR_W, 32, byte address width of requests and of mem_addr.
- DATA_W, 32, data width; fixed at 32, not a true generic.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  zero-extend loads (lbu/lhu) when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- stall  out  1  hold upstream request and pipeline.
- load_data  out  DATA_W  registered extended load result.
- load_valid  out  1  load_data valid, 1-cycle pulse.
- misalign_exc  out  1  registered misalignment flag, 1-cycle pulse.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_addr  out  ADDR_W  to data memory Address, word-aligned ([1:0]=00).
- mem_wdata  out  DATA_W  to data memory Write_data.
- mem_rdata  in  DATA_W  from data memory Read_data, combinational.

Behaviour:
- Reset: state IDLE; load_data=0, load_valid=0, misalign_exc=0. Combinational outputs stall, mem_read, mem_write=0 and mem_addr, mem_wdata=0 while in IDLE with no request.
- Byte lanes are little-endian. Byte lane k = addr[1:0]; half lane = addr[1]. mem_addr = {req_addr[ADDR_W-1:2], 2'b00}.
- FSM states: IDLE, RMW_WR.
- IDLE + valid load, aligned:
  - mem_read=1.
  - At the clock edge, load_data <= extended lane of mem_rdata; load_valid <= 1.
  - stall=0; latency 1 cycle.
- IDLE + valid word store, aligned: mem_write=1, mem_wdata=req_wdata, stall=0. Memory is written at this edge; no state change.
- IDLE + valid byte/half store, aligned:
  - mem_read=1, stall=1.
  - At the edge, latch merged word (mem_rdata with the target lane replaced by req_wdata low bits) and the word address. Go to RMW_WR.
- RMW_WR:
  - mem_write=1, mem_addr/mem_wdata come from the latches, stall=0, mem_read=0.
  - Request inputs are ignored; they are the held request.
  - Return to IDLE at the edge.
- Misaligned request (half with addr[0]=1; word with addr[1:0]!=0):
  - No mem_read or mem_write.
  - misalign_exc <= 1 for one cycle; load_valid stays 0; stall=0.
- req_valid=0: load_valid and misalign_exc clear to 0 at the next edge.
- Extension: byte loads sign-extend from bit 7 and halfword loads from bit 15, unless req_unsigned=1. Word loads pass through unchanged.
- Reset asserted mid-RMW (in RMW_WR): immediate return to IDLE, no write issued, latches cleared.
- mem_read and mem_write are never both 1 in the same cycle.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: misalignment is detected and reported as above.
- Undefined:
  - misalign_exc is tied to 0.
  - Misaligned addresses are force-aligned: half uses addr[1] only, word ignores addr[1:0].
  - The access then proceeds normally.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - FSM state enum (IDLE, RMW_WR);
  - DATA_W constant.
- One sub-module, load_extend: combinational lane select plus sign/zero extension, reused for load return.

Test Plan:
- Preload word 0x20 = 0x80FF7F01. lb 0x23 -> load_data=0xFFFFFF80; lbu 0x23 -> 0x00000080. load_valid pulses 1 cycle after each request.
- Same preload. lh 0x22 -> 0xFFFF80FF; lhu 0x20 -> 0x00007F01; lw 0x20 -> 0x80FF7F01.
- sb 0x21, wdata 0x000000AA:
  - stall=1 for exactly one cycle;
  - then mem_write=1 with mem_wdata=0x80FFAA01 at mem_addr 0x20;
  - lw 0x20 then returns 0x80FFAA01.
- sw 0x24, wdata 0xDEADBEEF: single cycle, stall never asserts, then lw 0x24 -> 0xDEADBEEF. Back-to-back sh 0x26 (0x1234) then yields 0x1234BEEF.
- With the macro defined: lw 0x22 -> misalign_exc pulse, mem_write/mem_read never asserted, load_valid=0. Without the macro: same request returns the word at 0x20.
- sh 0x28 issued, rst asserted during RMW_WR -> no mem_write observed; word 0x28 unchanged; all outputs 0; FSM in IDLE.
